logic_mux2_stim: RTL and testbench

Upstream stimulus sequencer for the `Logic_mux2` stage. On a `start` pulse it drives a fixed-length sequence of 3-bit input vectors onto `a`, `b` and `c`, holding each vector for a programmable number of cycles. It samples the stage's `y` output at the end of each vector into a response word and signals completion with a one-cycle `done` pulse. This lets the mux be exercised in-system without a behavioural testbench.

---
 rtl/logic_mux2_stim.sv | 108 ++++++++++
 tb/tb_logic_mux2_stim.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_mux2_stim.sv
// rtl/logic_mux2_stim.sv - stimulus sequencer driving a/b/c vectors into Logic_mux2 and capturing y
// Binary or Gray 3-bit vectors, each held HOLD_CYCLES, responses packed into resp.
module logic_mux2_stim #(
  parameter int HOLD_CYCLES = 1,
  parameter int NUM_VECTORS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic       y_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] resp
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [2:0] IDX_LAST  = 3'(NUM_VECTORS - 1);

  state_t     state_q, state_d;
  logic       mode_q, mode_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] vec_q, vec_d;
  logic       busy_d, done_d;
  logic [7:0] resp_q, resp_d;

  function automatic logic [2:0] pattern(input logic [2:0] i, input logic m);
    return m ? (i ^ (i >> 1)) : i;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      hold_q  <= '0;
      vec_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
      busy    <= busy_d;
      done    <= done_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    vec_d   = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    resp_d  = resp_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode;
          resp_d  = '0;
          idx_d   = '0;
          hold_d  = '0;
          vec_d   = pattern(3'd0, mode);
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        vec_d  = vec_q;
        if (hold_q == HOLD_LAST) begin
          // y_in has had HOLD_CYCLES full cycles to settle on the current vector
          resp_d[idx_q] = y_in;
          hold_d        = '0;
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            vec_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
            vec_d = pattern(idx_q + 3'd1, mode_q);
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign {a, b, c} = vec_q;
  assign resp      = resp_q;

endmodule

// File: tb/tb_logic_mux2_stim.sv
// tb/tb_logic_mux2_stim.sv - self-checking bench for logic_mux2_stim
// Three instances with different HOLD/NUM settings checked cycle by cycle against a sequence model.
module tb_logic_mux2_stim;

  localparam int HOLD_P[3] = '{1, 3, 2};
  localparam int NUM_P[3]  = '{8, 4, 5};

  logic       clk;
  logic       rst_n;
  logic       start_v[3];
  logic       mode_v[3];
  logic       yr[3];
  logic [1:0] sel[3];
  logic       y_in_w[3];
  logic       a_o[3], b_o[3], c_o[3], busy_o[3], done_o[3];
  logic [7:0] resp_o[3];

  int compared;
  int mismatched;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_ysel
    assign y_in_w[g] = (sel[g] == 2'd0) ? a_o[g] :
                       (sel[g] == 2'd1) ? b_o[g] :
                       (sel[g] == 2'd2) ? c_o[g] : yr[g];
  end

  logic_mux2_stim #(.HOLD_CYCLES(1), .NUM_VECTORS(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode_v[0]), .y_in(y_in_w[0]),
    .a(a_o[0]), .b(b_o[0]), .c(c_o[0]), .busy(busy_o[0]), .done(done_o[0]), .resp(resp_o[0]));
  logic_mux2_stim #(.HOLD_CYCLES(3), .NUM_VECTORS(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode_v[1]), .y_in(y_in_w[1]),
    .a(a_o[1]), .b(b_o[1]), .c(c_o[1]), .busy(busy_o[1]), .done(done_o[1]), .resp(resp_o[1]));
  logic_mux2_stim #(.HOLD_CYCLES(2), .NUM_VECTORS(5)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode_v[2]), .y_in(y_in_w[2]),
    .a(a_o[2]), .b(b_o[2]), .c(c_o[2]), .busy(busy_o[2]), .done(done_o[2]), .resp(resp_o[2]));

  function automatic int pat(input int i, input int m);
    return (m != 0) ? ((i ^ (i / 2)) % 8) : (i % 8);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      start_v[u] = 1'b1; mode_v[u] = 1'b1; sel[u] = 2'd3; yr[u] = 1'b1;
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
        compared++;
        if ({a_o[u], b_o[u], c_o[u], busy_o[u], done_o[u]} !== 5'b0 || resp_o[u] !== 8'h00) begin
          mismatched++;
          $display("FAIL reset u%0d: abc_busy_done=%b resp=%h, required 00000 / 00", u,
                   {a_o[u], b_o[u], c_o[u], busy_o[u], done_o[u]}, resp_o[u]);
        end
      end
    end
    for (int u = 0; u < 3; u++) start_v[u] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // one run from E0 through the IDLE cycle after DONE; s selects y source (0=a,1=b,2=c,3=random)
  task automatic run_seq(input int u, input int m, input int s, input bit restart, input string tag,
                         output logic [7:0] final_resp);
    int h, n, k, ev;
    logic [7:0] er;
    h = HOLD_P[u]; n = NUM_P[u]; er = 8'h00;
    @(negedge clk);
    mode_v[u] = m[0]; sel[u] = s[1:0]; start_v[u] = 1'b1; yr[u] = 1'($urandom % 2);
    for (int ph = 0; ph <= n * h + 1; ph++) begin
      if (ph > 0) begin
        @(negedge clk);
        start_v[u] = restart && (ph == 5);
        mode_v[u]  = ~m[0];
        yr[u]      = 1'($urandom % 2);
      end
      if (ph >= h && ph % h == 0 && ph <= n * h) begin
        k = ph / h - 1;
        er[k] = (s == 3) ? yr[u] : 1'((pat(k, m) >> (2 - s)) & 1);
      end
      @(posedge clk);
      #1;
      ev = (ph < n * h) ? pat(ph / h, m) : 0;
      compared++;
      if ({a_o[u], b_o[u], c_o[u]} !== 3'(ev) || busy_o[u] !== (ph < n * h) ||
          done_o[u] !== (ph == n * h) || resp_o[u] !== er) begin
        mismatched++;
        $display("FAIL %s ph=%0d: abc=%b busy=%b done=%b resp=%h, required abc=%b busy=%b done=%b resp=%h",
                 tag, ph, {a_o[u], b_o[u], c_o[u]}, busy_o[u], done_o[u], resp_o[u],
                 3'(ev), (ph < n * h), (ph == n * h), er);
      end
    end
    start_v[u] = 1'b0;
    final_resp = er;
  endtask

  task automatic test_binary();
    logic [7:0] r;
    run_seq(0, 0, 0, 1'b0, "binary", r);
    compared++;
    if (r !== 8'hF0 || resp_o[0] !== 8'hF0) begin
      mismatched++;
      $display("FAIL binary_resp: resp=%h, required f0", resp_o[0]);
    end
  endtask

  task automatic test_gray();
    logic [7:0] r;
    run_seq(0, 1, 2, 1'b0, "gray", r);
    compared++;
    if (resp_o[0] !== 8'h66) begin
      mismatched++;
      $display("FAIL gray_resp: resp=%h, required 66", resp_o[0]);
    end
  endtask

  task automatic test_held();
    logic [7:0] r;
    run_seq(1, 0, 1, 1'b1, "held", r);
    compared++;
    if (resp_o[1] !== 8'h0C) begin
      mismatched++;
      $display("FAIL held_resp: resp=%h, required 0c", resp_o[1]);
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    for (int it = 0; it < 6; it++) begin
      run_seq(it % 3, int'($urandom % 2), 3, 1'b0, "random", r);
      compared++;
      if (resp_o[it % 3] !== r || (r >> NUM_P[it % 3]) !== 8'h00) begin
        mismatched++;
        $display("FAIL random_resp u%0d: resp=%h, required %h", it % 3, resp_o[it % 3], r);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] r;
    @(negedge clk);
    sel[0] = 2'd3; yr[0] = 1'b1; mode_v[0] = 1'b0; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    compared++;
    if (resp_o[0] !== 8'h0F || busy_o[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL midrun_pre: resp=%h busy=%b, required 0f 1", resp_o[0], busy_o[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({a_o[0], b_o[0], c_o[0], busy_o[0], done_o[0]} !== 5'b0 || resp_o[0] !== 8'h00) begin
      mismatched++;
      $display("FAIL midrun_async: abc_busy_done=%b resp=%h, required 00000 / 00",
               {a_o[0], b_o[0], c_o[0], busy_o[0], done_o[0]}, resp_o[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(0, 1, 0, 1'b0, "after_reset", r);
  endtask

  task automatic test_back_to_back();
    int h, n, per, ph, k, ev;
    logic [7:0] er;
    h = HOLD_P[2]; n = NUM_P[2]; per = n * h + 2; er = 8'h00;
    @(negedge clk);
    sel[2] = 2'd3; mode_v[2] = 1'b1; start_v[2] = 1'b1; yr[2] = 1'($urandom % 2);
    for (int t = 0; t < 3 * per; t++) begin
      ph = t % per;
      if (t > 0) begin
        @(negedge clk);
        yr[2] = 1'($urandom % 2);
      end
      if (ph == 0) er = 8'h00;
      if (ph >= h && ph % h == 0 && ph <= n * h) begin
        k = ph / h - 1;
        er[k] = yr[2];
      end
      @(posedge clk);
      #1;
      ev = (ph < n * h) ? pat(ph / h, 1) : 0;
      compared++;
      if ({a_o[2], b_o[2], c_o[2]} !== 3'(ev) || busy_o[2] !== (ph < n * h) ||
          done_o[2] !== (ph == n * h) || resp_o[2] !== er) begin
        mismatched++;
        $display("FAIL back_to_back t=%0d: abc=%b busy=%b done=%b resp=%h, required abc=%b busy=%b done=%b resp=%h",
                 t, {a_o[2], b_o[2], c_o[2]}, busy_o[2], done_o[2], resp_o[2],
                 3'(ev), (ph < n * h), (ph == n * h), er);
      end
    end
    start_v[2] = 1'b0;
    repeat (per) @(negedge clk);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    for (int u = 0; u < 3; u++) begin
      start_v[u] = 1'b0; mode_v[u] = 1'b0; yr[u] = 1'b0; sel[u] = 2'd0;
    end
    test_reset();
    test_binary();
    test_gray();
    test_held();
    test_random();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
